// File: rtl/carpma_birimi.sv
// Multi-cycle RV32M multiplier: 33x17 partial products over four cycles,
// with a registered 32-bit result that is held while write-back stalls.
module carpma_birimi (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        basla_i,
  input  logic [1:0]  islem_i,
  input  logic [31:0] deger1_i,
  input  logic [31:0] deger2_i,
  input  logic        durdur_i,
  input  logic        iptal_i,
  output logic        mesgul_o,
  output logic        gecerli_o,
  output logic [31:0] sonuc_o
);

  typedef enum logic [2:0] {
    BOSTA  = 3'd0,
    KISMI0 = 3'd1,
    KISMI1 = 3'd2,
    TOPLA  = 3'd3,
    SONUC  = 3'd4
  } durum_t;

  durum_t durum, durum_n;

  logic signed [32:0] a33;
  logic signed [32:0] b33;
  logic               ust;
  logic signed [49:0] p0;
  logic signed [49:0] p1;
  logic signed [49:0] p0_n;
  logic signed [49:0] p1_n;
  logic [31:0]        sonuc;
  logic               kabul;
  logic               sa;
  logic               sb;

  function automatic logic signed [49:0] sext50_33(input logic signed [32:0] x);
    return {{17{x[32]}}, x};
  endfunction

  function automatic logic signed [49:0] sext50_17(input logic signed [16:0] x);
    return {{33{x[16]}}, x};
  endfunction

  // Recombine the two partial products and pick the requested 32-bit half.
  function automatic logic [31:0] yarim_sec(input logic signed [49:0] k0,
                                            input logic signed [49:0] k1,
                                            input logic               ust_sec);
    logic signed [65:0] carpim;
    carpim = {{16{k0[49]}}, k0} + {k1, 16'h0000};
    return ust_sec ? carpim[63:32] : carpim[31:0];
  endfunction

  assign mesgul_o  = (durum == KISMI0) || (durum == KISMI1) || (durum == TOPLA) ||
                     ((durum == SONUC) && durdur_i);
  assign gecerli_o = (durum == SONUC);
  assign sonuc_o   = sonuc;
  assign kabul     = basla_i && !mesgul_o && !iptal_i;

  // Operand sign extension: only MULHU treats rs1 as unsigned, MULHSU/MULHU rs2.
  assign sa = (islem_i != 2'b11);
  assign sb = !islem_i[1];

  assign p0_n = sext50_33(a33) * sext50_17($signed({1'b0, b33[15:0]}));
  assign p1_n = sext50_33(a33) * sext50_17(b33[32:16]);

  always_comb begin
    durum_n = durum;
    case (durum)
      BOSTA:   if (kabul) durum_n = KISMI0;
      KISMI0:  durum_n = KISMI1;
      KISMI1:  durum_n = TOPLA;
      TOPLA:   durum_n = SONUC;
      SONUC: begin
        if (durdur_i)   durum_n = SONUC;
        else if (kabul) durum_n = KISMI0;
        else            durum_n = BOSTA;
      end
      default: durum_n = BOSTA;
    endcase
    if (iptal_i) durum_n = BOSTA;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum <= BOSTA;
      a33   <= '0;
      b33   <= '0;
      ust   <= 1'b0;
      p0    <= '0;
      p1    <= '0;
      sonuc <= '0;
    end else begin
      durum <= durum_n;
      // operand capture stage
      if (kabul) begin
        a33 <= {sa & deger1_i[31], deger1_i};
        b33 <= {sb & deger2_i[31], deger2_i};
        ust <= (islem_i != 2'b00);
      end
      // partial product stages
      if (durum == KISMI0) p0 <= p0_n;
      if (durum == KISMI1) p1 <= p1_n;
      // summation stage; a flush in the same cycle discards the result
      if ((durum == TOPLA) && !iptal_i) sonuc <= yarim_sec(p0, p1, ust);
    end
  end

endmodule

// File: tb/tb_carpma_birimi.sv
// Scoreboard bench for carpma_birimi: directed cases plus random operands
// checked against a plain 64-bit product model.
module tb_carpma_birimi;

  logic        clk = 1'b0;
  logic        rst;
  logic        basla;
  logic [1:0]  islem;
  logic [31:0] d1;
  logic [31:0] d2;
  logic        durdur;
  logic        iptal;
  logic        mesgul;
  logic        gecerli;
  logic [31:0] sonuc;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cur_exp  = '0;
  logic [31:0] last_exp = '0;
  logic        prev_g   = 1'b0;

  carpma_birimi dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .basla_i  (basla),
    .islem_i  (islem),
    .deger1_i (d1),
    .deger2_i (d2),
    .durdur_i (durdur),
    .iptal_i  (iptal),
    .mesgul_o (mesgul),
    .gecerli_o(gecerli),
    .sonuc_o  (sonuc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ax, bx, pr;
    ax = (op != 2'b11)   ? {{32{a[31]}}, a} : {32'h0, a};
    bx = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'h0, b};
    pr = ax * bx;
    return (op == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h required=%h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one pop per valid pulse, value must stay put while held.
  always @(negedge clk) begin
    if (rst) begin
      prev_g = 1'b0;
    end else begin
      if (gecerli && !prev_g) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result got=%h required=none at %0t", sonuc, $time);
        end else begin
          cur_exp  = exp_q.pop_front();
          last_exp = cur_exp;
          chk("result", sonuc, cur_exp);
        end
      end else if (gecerli) begin
        chk("hold", sonuc, cur_exp);
      end
      prev_g = gecerli;
    end
  end

  // Present an operation, wait for acceptance, push its expectation.
  // Returns 1 time unit into the cycle after acceptance (T+1).
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    basla = 1'b1;
    islem = op;
    d1 = a;
    d2 = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mesgul) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got=busy required=idle at %0t", $time);
    end else begin
      exp_q.push_back(model(op, a, b));
    end
    @(posedge clk);
    #1;
    basla = 1'b0;
  endtask

  task automatic busy_3();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy", mesgul, 1);
      chk("early_valid", gecerli, 0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(op, a, b);
    busy_3();
    @(negedge clk);
    chk("valid_at_t4", gecerli, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners[5];
    corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog got=running required=finished at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; basla = 1'b0; islem = 2'b00; d1 = '0; d2 = '0;
    durdur = 1'b0; iptal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sonuc", sonuc, 0);
    chk("reset_gecerli", gecerli, 0);
    chk("reset_mesgul", mesgul, 0);
    @(posedge clk);
    #1;

    run_op(2'b00, 32'd7, 32'hFFFFFFFD);
    chk("mul_neg", last_exp, 32'hFFFFFFEB);
    run_op(2'b01, 32'h80000000, 32'h80000000);
    chk("mulh_min", last_exp, 32'h40000000);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulhsu_m1", last_exp, 32'hFFFFFFFF);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulhu_max", last_exp, 32'hFFFFFFFE);

    // Stall at T+4..T+6 with a new request presented during the stall
    start_op(2'b00, 32'h12345678, 32'h9ABCDEF0);
    durdur = 1'b1;
    busy_3();
    basla = 1'b1; islem = 2'b11; d1 = 32'hFFFFFFFF; d2 = 32'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", gecerli, 1);
      chk("stall_busy", mesgul, 1);
      @(posedge clk);
      #1;
    end
    durdur = 1'b0;
    @(negedge clk);
    chk("stall_release_busy", mesgul, 0);
    chk("stall_release_valid", gecerli, 1);
    exp_q.push_back(model(2'b11, 32'hFFFFFFFF, 32'd2));
    @(posedge clk);
    #1;
    basla = 1'b0;
    busy_3();
    @(negedge clk);
    chk("after_stall_valid", gecerli, 1);
    @(posedge clk);
    #1;

    // Back-to-back acceptance in the SONUC cycle
    start_op(2'b00, 32'd11, 32'd13);
    busy_3();
    basla = 1'b1; islem = 2'b00; d1 = 32'd3; d2 = 32'd5;
    @(negedge clk);
    chk("b2b_valid1", gecerli, 1);
    chk("b2b_busy", mesgul, 0);
    exp_q.push_back(model(2'b00, 32'd3, 32'd5));
    @(posedge clk);
    #1;
    basla = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_gap", gecerli, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("b2b_valid2", gecerli, 1);
    chk("b2b_value", sonuc, 32'h0000000F);
    @(posedge clk);
    #1;

    // Flush in KISMI1
    start_op(2'b01, 32'h55555555, 32'h77777777);
    @(posedge clk);
    #1;
    iptal = 1'b1;
    @(posedge clk);
    #1;
    iptal = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_valid", gecerli, 0);
      chk("flush_busy", mesgul, 0);
      chk("flush_keep", sonuc, 32'h0000000F);
      @(posedge clk);
      #1;
    end

    // Reset in TOPLA
    start_op(2'b00, 32'd9, 32'd9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_sonuc", sonuc, 0);
    chk("rst_mid_valid", gecerli, 0);
    chk("rst_mid_busy", mesgul, 0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 10000; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op(op, a, b);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carpma_birimi.md
# carpma_birimi

Multi-cycle 32x32 integer multiplier of the execute stage (RV32M MUL/MULH/MULHSU/MULHU). Accepts operands from the execute datapath and produces its own registered result. That result feeds the write-back stage's multiplier-value input (write-back source CARP). It computes the 66-bit signed product as two 33x17 partial products summed over a fixed four-cycle sequence, and holds the result under downstream stall.

## Interface
- No parameters.
- clk_i  input  1  core clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- basla_i  input  1  start request; accepted only when mesgul_o=0
- islem_i  input  2  00 MUL (low), 01 MULH (s x s, high), 10 MULHSU (s x u, high), 11 MULHU (u x u, high); sampled with basla_i
- deger1_i  input  32  rs1 operand (a); sampled with basla_i
- deger2_i  input  32  rs2 operand (b); sampled with basla_i
- durdur_i  input  1  downstream stall; holds SONUC
- iptal_i  input  1  pipeline flush; aborts any operation
- mesgul_o  output  1  unit cannot accept basla_i this cycle
- gecerli_o  output  1  sonuc_o valid (high only in SONUC)
- sonuc_o  output  32  registered result to write-back

## Operation
- States: BOSTA, KISMI0, KISMI1, TOPLA, SONUC; reset -> BOSTA.
- Accept = basla_i & ~mesgul_o & ~iptal_i.
  - Latches a33 = {sa & a[31], a} and b33 = {sb & b[31], b}.
    - MUL, MULH: sa=1, sb=1.
    - MULHSU: sa=1, sb=0.
    - MULHU: sa=0, sb=0.
  - Latches ust = (islem_i != 00).
  - Next state KISMI0.
- KISMI0: p0 <= signed(a33) * signed({1'b0, b33[15:0]}) (50-bit signed) -> KISMI1.
- KISMI1: p1 <= signed(a33) * signed(b33[32:16]) (50-bit signed) -> TOPLA.
- TOPLA: carpim = sext66(p0) + (sext66(p1) << 16); sonuc_o <= ust ? carpim[63:32] : carpim[31:0] -> SONUC.
- SONUC:
  - durdur_i=1: stay; sonuc_o and gecerli_o held.
  - durdur_i=0 and accept: KISMI0 with new operands (back-to-back).
  - Otherwise: BOSTA.
- mesgul_o = state in {KISMI0, KISMI1, TOPLA} | (state==SONUC & durdur_i).
- gecerli_o = (state==SONUC).
- iptal_i=1 in any state: next state BOSTA, no accept that cycle. sonuc_o is not modified, except that a TOPLA completion in the same cycle is discarded.
- rst_i has priority over iptal_i, which has priority over basla_i and durdur_i.
- sonuc_o keeps its last value outside SONUC; it changes only on a TOPLA->SONUC transition.

## Timing
- Reset values: state BOSTA, sonuc_o 32'h0, gecerli_o 0, mesgul_o 0; p0, p1, a33, b33 and ust reset to 0.
- Latency: basla_i accepted in cycle T gives gecerli_o=1 in cycle T+4, with sonuc_o valid in the same cycle.
- Throughput: one operation per 4 cycles when results are accepted back-to-back (accept in SONUC).
- mesgul_o is a function of registered state and durdur_i only. It has no path from basla_i or operands.
- basla_i while mesgul_o=1 is ignored. The requester holds basla_i and operands until mesgul_o=0.
- Reset or flush mid-operation: the following cycle is BOSTA with gecerli_o=0, and no late result ever appears.

## Test plan
- Reset and basic MUL:
  - Assert rst_i for 2 cycles: all outputs 0.
  - MUL 7 x 32'hFFFFFFFD: mesgul_o=1 for T+1..T+3; gecerli_o=1 at T+4 with sonuc_o=32'hFFFFFFEB.
- High-half variants (each gives a single gecerli_o pulse):
  - MULH 32'h80000000 x 32'h80000000 -> 32'h40000000.
  - MULHSU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFF.
  - MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE.
- Stall: durdur_i=1 at T+4..T+6.
  - gecerli_o and sonuc_o are held through T+6; mesgul_o=1 throughout.
  - A basla_i issued during the stall is ignored until durdur_i drops.
- Back-to-back: a second MUL 3 x 5 is accepted in the SONUC cycle (T+4) of the first. It gives gecerli_o at T+8 with 32'h0000000F, and gecerli_o=0 in T+5..T+7.
- Flush and reset mid-operation:
  - iptal_i in KISMI1: BOSTA next cycle; gecerli_o is never asserted; sonuc_o keeps its previous value.
  - Repeat with rst_i in TOPLA: sonuc_o=0, gecerli_o=0 next cycle.
- Random: 10k random operands and islem_i, compared against a 64-bit reference product; includes a, b in {0, 1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF}.
